dmi_req_handler: RTL and testbench



---
 rtl/dmi_pkg.sv | 39 +++
 rtl/dmi_req_handler.sv | 154 +++++++++++++++
 tb/tb_dmi_req_handler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared constants for the DMI request handler: widths, field offsets,
// op/status encodings and FSM state encoding.
package dmi_pkg;

  localparam int unsigned DmiAddrWidth = 7;
  localparam int unsigned DmiDataWidth = 32;
  localparam int unsigned DmiOpWidth   = 2;

  // creq_data = {addr, data, op}
  localparam int unsigned CreqOpLsb   = 0;
  localparam int unsigned CreqDataLsb = DmiOpWidth;
  localparam int unsigned CreqAddrLsb = DmiOpWidth + DmiDataWidth;

  // cresp_data = {data, status}
  localparam int unsigned CrespStatusLsb = 0;
  localparam int unsigned CrespDataLsb   = DmiOpWidth;

  typedef enum logic [1:0] {
    OpNop   = 2'd0,
    OpRead  = 2'd1,
    OpWrite = 2'd2,
    OpRsvd  = 2'd3
  } dmi_op_e;

  // BUSY is reserved for the upstream JTAG side and never produced here.
  typedef enum logic [1:0] {
    StatusSuccess = 2'd0,
    StatusFailed  = 2'd2,
    StatusBusy    = 2'd3
  } dmi_status_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } dmi_state_e;

endpackage

// File: rtl/dmi_req_handler.sv
// Core-side DMI request handler: turns one DMI request into one debug-bus
// access and returns the DMI response, with a per-access timeout.
module dmi_req_handler
  import dmi_pkg::*;
#(
  parameter int unsigned DMI_ADDR_WIDTH = DmiAddrWidth,
  parameter int unsigned DMI_DATA_WIDTH = DmiDataWidth,
  parameter int unsigned DMI_OP_WIDTH   = DmiOpWidth,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                creq_vld,
  input  logic [DMI_ADDR_WIDTH+DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0] creq_data,
  output logic                                                creq_rdy,
  output logic                                                cresp_vld,
  output logic [DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0]                cresp_data,
  input  logic                                                cresp_rdy,
  output logic                                                dm_req_vld,
  input  logic                                                dm_req_rdy,
  output logic [DMI_ADDR_WIDTH-1:0]                             dm_addr,
  output logic [DMI_DATA_WIDTH-1:0]                             dm_wdata,
  output logic                                                dm_wen,
  input  logic                                                dm_resp_vld,
  input  logic [DMI_DATA_WIDTH-1:0]                             dm_rdata,
  input  logic                                                dm_err,
  output logic                                                err_sticky
);

  localparam int unsigned AddrLsb = DMI_OP_WIDTH + DMI_DATA_WIDTH;
  localparam int unsigned DataLsb = DMI_OP_WIDTH;
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [DMI_OP_WIDTH-1:0] OpNopW    = DMI_OP_WIDTH'(OpNop);
  localparam logic [DMI_OP_WIDTH-1:0] OpReadW   = DMI_OP_WIDTH'(OpRead);
  localparam logic [DMI_OP_WIDTH-1:0] OpWriteW  = DMI_OP_WIDTH'(OpWrite);
  localparam logic [DMI_OP_WIDTH-1:0] StSuccessW = DMI_OP_WIDTH'(StatusSuccess);
  localparam logic [DMI_OP_WIDTH-1:0] StFailedW  = DMI_OP_WIDTH'(StatusFailed);

  dmi_state_e                state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DMI_OP_WIDTH-1:0]   op_q, op_d;
  logic [DMI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DMI_OP_WIDTH-1:0]   status_q, status_d;
  logic                      err_q, err_d;

  logic [DMI_OP_WIDTH-1:0]   req_op;
  logic                      expired;

  assign req_op  = creq_data[DMI_OP_WIDTH-1:0];
  // Current cycle is the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
  assign expired = (cnt_q == CntLast);

  // State and captured-transaction registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  // Next-state, capture and timeout logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    rdata_d  = rdata_q;
    status_d = status_q;

    unique case (state_q)
      StIdle: begin
        if (creq_vld) begin
          addr_d  = creq_data[AddrLsb +: DMI_ADDR_WIDTH];
          wdata_d = creq_data[DataLsb +: DMI_DATA_WIDTH];
          op_d    = req_op;
          cnt_d   = '0;
          rdata_d = '0;
          if (req_op == OpReadW || req_op == OpWriteW) begin
            state_d = StReq;
          end else begin
            state_d  = StResp;
            status_d = (req_op == OpNopW) ? StSuccessW : StFailedW;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (dm_req_rdy && dm_resp_vld) begin
          state_d  = StResp;
          rdata_d  = (op_q == OpReadW) ? dm_rdata : '0;
          status_d = dm_err ? StFailedW : StSuccessW;
        end else if (expired) begin
          state_d  = StResp;
          rdata_d  = '0;
          status_d = StFailedW;
        end else if (dm_req_rdy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A completion in the expiry cycle beats the timeout.
        if (dm_resp_vld) begin
          state_d  = StResp;
          rdata_d  = (op_q == OpReadW) ? dm_rdata : '0;
          status_d = dm_err ? StFailedW : StSuccessW;
        end else if (expired) begin
          state_d  = StResp;
          rdata_d  = '0;
          status_d = StFailedW;
        end
      end
      StResp: begin
        if (cresp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Rises together with cresp_vld for a FAILED response.
    err_d = err_q | ((state_d == StResp) && (status_d == StFailedW));
  end

  // Held low while reset is asserted so every output reads 0 during reset.
  assign creq_rdy   = (state_q == StIdle) && !reset;
  assign cresp_vld  = (state_q == StResp);
  assign cresp_data = {rdata_q, status_q};
  assign dm_req_vld = (state_q == StReq);
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign dm_wen     = (op_q == OpWriteW);
  assign err_sticky = err_q;

endmodule

// File: tb/tb_dmi_req_handler.sv
// Directed bench for dmi_req_handler with hand-computed expectations.
module tb_dmi_req_handler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        creq_vld = 1'b0;
  logic [40:0] creq_data = '0;
  logic        creq_rdy;
  logic        cresp_vld;
  logic [33:0] cresp_data;
  logic        cresp_rdy = 1'b0;
  logic        dm_req_vld;
  logic        dm_req_rdy = 1'b0;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wen;
  logic        dm_resp_vld = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        dm_err = 1'b0;
  logic        err_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  dmi_req_handler #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .creq_vld    (creq_vld),
    .creq_data   (creq_data),
    .creq_rdy    (creq_rdy),
    .cresp_vld   (cresp_vld),
    .cresp_data  (cresp_data),
    .cresp_rdy   (cresp_rdy),
    .dm_req_vld  (dm_req_vld),
    .dm_req_rdy  (dm_req_rdy),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_wen      (dm_wen),
    .dm_resp_vld (dm_resp_vld),
    .dm_rdata    (dm_rdata),
    .dm_err      (dm_err),
    .err_sticky  (err_sticky)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Presents one request in IDLE; returns at the negedge after acceptance.
  task automatic send_req(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op);
    creq_vld  = 1'b1;
    creq_data = {addr, data, op};
    check("creq_rdy_idle", creq_rdy, 1);
    tick();
    creq_vld  = 1'b0;
    creq_data = '0;
  endtask

  task automatic resp_handshake();
    cresp_rdy = 1'b1;
    tick();
    cresp_rdy = 1'b0;
    check("cresp_vld_after_hs", cresp_vld, 0);
  endtask

  initial begin
    // Reset values
    #1 reset = 1'b1;
    #2;
    check("rst_creq_rdy", creq_rdy, 0);
    check("rst_cresp_vld", cresp_vld, 0);
    check("rst_dm_req_vld", dm_req_vld, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_cresp_data", cresp_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // READ 0x11: rdy after 2 cycles, response 3 cycles into WAIT
    send_req(7'h11, 32'h0, 2'd1);
    check("rd_dm_req_vld", dm_req_vld, 1);
    check("rd_dm_addr", dm_addr, 64'h11);
    check("rd_dm_wen", dm_wen, 0);
    check("rd_creq_rdy_busy", creq_rdy, 0);
    tick();
    check("rd_req_hold", dm_req_vld, 1);
    tick();
    dm_req_rdy = 1'b1;
    tick();
    dm_req_rdy = 1'b0;
    check("rd_wait_vld_low", dm_req_vld, 0);
    tick();
    tick();
    dm_resp_vld = 1'b1;
    dm_rdata    = 32'hDEAD_BEEF;
    tick();
    dm_resp_vld = 1'b0;
    dm_rdata    = '0;
    check("rd_cresp_vld", cresp_vld, 1);
    check("rd_cresp_data", cresp_data, {30'd0, 32'hDEAD_BEEF, 2'b00});
    check("rd_err_sticky", err_sticky, 0);
    resp_handshake();

    // WRITE 0x10 <= 1, zero-wait slave
    send_req(7'h10, 32'h1, 2'd2);
    check("wr_dm_wen", dm_wen, 1);
    check("wr_dm_wdata", dm_wdata, 64'h1);
    check("wr_dm_addr", dm_addr, 64'h10);
    dm_req_rdy  = 1'b1;
    dm_resp_vld = 1'b1;
    dm_rdata    = 32'h5555_5555;
    tick();
    dm_req_rdy  = 1'b0;
    dm_resp_vld = 1'b0;
    dm_rdata    = '0;
    check("wr_cresp_vld", cresp_vld, 1);
    check("wr_cresp_data", cresp_data, 0);
    resp_handshake();

    // NOP then reserved op, each stalled 4 cycles
    send_req(7'h00, 32'h0, 2'd0);
    check("nop_cresp_vld", cresp_vld, 1);
    check("nop_cresp_data", cresp_data, 0);
    creq_vld  = 1'b1;
    creq_data = {7'h7F, 32'hFFFF_FFFF, 2'd3};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nop_stall_vld", cresp_vld, 1);
      check("nop_stall_data", cresp_data, 0);
      check("nop_stall_creq_rdy", creq_rdy, 0);
    end
    cresp_rdy = 1'b1;
    tick();
    cresp_rdy = 1'b0;
    check("nop_back_idle", creq_rdy, 1);
    check("nop_vld_low", cresp_vld, 0);
    tick();
    creq_vld  = 1'b0;
    creq_data = '0;
    check("rsvd_cresp_vld", cresp_vld, 1);
    check("rsvd_cresp_data", cresp_data, 64'h2);
    check("rsvd_err_sticky", err_sticky, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rsvd_stall_data", cresp_data, 64'h2);
      check("rsvd_stall_creq_rdy", creq_rdy, 0);
    end
    resp_handshake();

    // Timeout: 8 cycles in REQ/WAIT with no completion
    send_req(7'h05, 32'h0, 2'd1);
    for (int k = 1; k <= 8; k++) begin
      check("to_pending", cresp_vld, 0);
      dm_req_rdy = (k == 1);
      tick();
    end
    dm_req_rdy = 1'b0;
    check("to_cresp_vld", cresp_vld, 1);
    check("to_cresp_data", cresp_data, 64'h2);
    check("to_dm_req_vld", dm_req_vld, 0);
    tick();
    dm_resp_vld = 1'b1;
    dm_rdata    = 32'h0000_ABCD;
    tick();
    dm_resp_vld = 1'b0;
    dm_rdata    = '0;
    check("to_late_ignored", cresp_data, 64'h2);
    resp_handshake();
    dm_resp_vld = 1'b1;
    tick();
    dm_resp_vld = 1'b0;
    check("idle_late_no_resp", cresp_vld, 0);
    check("idle_late_no_req", dm_req_vld, 0);
    send_req(7'h05, 32'h0, 2'd1);
    dm_req_rdy  = 1'b1;
    dm_resp_vld = 1'b1;
    dm_rdata    = 32'h1234_5678;
    tick();
    dm_req_rdy  = 1'b0;
    dm_resp_vld = 1'b0;
    dm_rdata    = '0;
    check("to_next_rd_data", cresp_data, {30'd0, 32'h1234_5678, 2'b00});
    resp_handshake();

    // READ with bus error; dm_err alone is ignored
    send_req(7'h22, 32'h0, 2'd1);
    dm_req_rdy = 1'b1;
    tick();
    dm_req_rdy = 1'b0;
    dm_err     = 1'b1;
    tick();
    dm_err = 1'b0;
    check("err_alone_ignored", cresp_vld, 0);
    dm_resp_vld = 1'b1;
    dm_err      = 1'b1;
    dm_rdata    = 32'hCAFE_F00D;
    tick();
    dm_resp_vld = 1'b0;
    dm_err      = 1'b0;
    dm_rdata    = '0;
    check("err_cresp_data", cresp_data, {30'd0, 32'hCAFE_F00D, 2'b10});
    check("err_sticky_set", err_sticky, 1);
    resp_handshake();
    check("err_sticky_hold", err_sticky, 1);

    // Reset while in WAIT
    send_req(7'h33, 32'hA5, 2'd2);
    dm_req_rdy = 1'b1;
    tick();
    dm_req_rdy = 1'b0;
    check("mid_wait_wen", dm_wen, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wen", dm_wen, 0);
    check("mid_rst_addr", dm_addr, 0);
    check("mid_rst_wdata", dm_wdata, 0);
    check("mid_rst_cresp_vld", cresp_vld, 0);
    check("mid_rst_creq_rdy", creq_rdy, 0);
    check("mid_rst_err_sticky", err_sticky, 0);
    tick();
    reset       = 1'b0;
    dm_resp_vld = 1'b1;
    tick();
    dm_resp_vld = 1'b0;
    check("post_rst_no_resp", cresp_vld, 0);
    check("post_rst_creq_rdy", creq_rdy, 1);
    send_req(7'h01, 32'h0, 2'd1);
    dm_req_rdy  = 1'b1;
    dm_resp_vld = 1'b1;
    dm_rdata    = 32'h0F0F_0F0F;
    tick();
    dm_req_rdy  = 1'b0;
    dm_resp_vld = 1'b0;
    dm_rdata    = '0;
    check("post_rst_rd_data", cresp_data, {30'd0, 32'h0F0F_0F0F, 2'b00});
    check("post_rst_sticky", err_sticky, 0);
    resp_handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
